// File: rtl/mdio_master_c22.sv
// mdio_master_c22 -- IEEE 802.3 Clause 22 MDIO management master.
//
// Takes one register read/write command over a cmd_valid/busy/ack handshake,
// serialises the management frame (preamble, ST, OP, PHYAD, REGAD, TA, DATA)
// on mdc/mdio, captures read data and reports a missing PHY through rd_err.
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   cmd_valid        command request, accepted when cmd_valid && !busy
//   cmd_read         1 = read (OP=10), 0 = write (OP=01)
//   cmd_phy/cmd_reg  5-bit PHY and register addresses
//   cmd_wdata        16-bit write data (ignored for reads)
//   busy             transaction in progress (cycle after accept .. ack cycle)
//   ack              one-cycle completion pulse
//   rdata            read data, updated on a read ack and held otherwise
//   rd_err           pulses with a read ack when the second TA bit reads 1
//   mdc              management clock (low phase then high phase per bit)
//   mdio_o/mdio_oe   MDIO output data and output enable
//   mdio_i           MDIO pad input (asynchronous, synchronised internally)
module mdio_master_c22 #(
    parameter int CLK_DIV  = 20,
    parameter int PRE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (PRE_BITS > 16) ? $clog2(PRE_BITS) : 4;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PRE_BITS - 1);
    localparam logic [BIT_W-1:0] HDR_LAST  = BIT_W'(13);
    localparam logic [BIT_W-1:0] TA_LAST   = BIT_W'(1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(15);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d, succ_s;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               rd_q, rd_d;
    logic [13:0]        hdr_q, hdr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rx_q, rx_d;
    logic               ta_err_q, ta_err_d;
    logic               sync1_q, sync2_q;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               rd_err_q, rd_err_d;
    logic               mdc_q, mdc_d;
    logic               mdio_o_q, mdio_o_d;
    logic               mdio_oe_q, mdio_oe_d;

    logic               accept_s;
    logic               bit_end_s;
    logic               last_bit_s;
    logic               frame_s;
    logic [13:0]        hdr_sh_s;
    logic [15:0]        wd_sh_s;

    assign accept_s  = (state_q == S_IDLE) && cmd_valid && !busy_q;
    // The synchronised input is sampled on the last clk of each high phase,
    // which is also the last clk of the bit.
    assign bit_end_s = (div_q == DIV_LAST);

    assign busy    = busy_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign rd_err  = rd_err_q;
    assign mdc     = mdc_q;
    assign mdio_o  = mdio_o_q;
    assign mdio_oe = mdio_oe_q;

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= {DIV_W{1'b0}};
            bit_q     <= {BIT_W{1'b0}};
            rd_q      <= 1'b0;
            hdr_q     <= 14'h0000;
            wdata_q   <= 16'h0000;
            rx_q      <= 16'h0000;
            ta_err_q  <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 16'h0000;
            rd_err_q  <= 1'b0;
            mdc_q     <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            rd_q      <= rd_d;
            hdr_q     <= hdr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            ta_err_q  <= ta_err_d;
            sync1_q   <= mdio_i;
            sync2_q   <= sync1_q;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            rd_err_q  <= rd_err_d;
            mdc_q     <= mdc_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
        end
    end

    // Next state plus divider and per-field bit counter.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        last_bit_s = 1'b0;
        succ_s     = S_IDLE;
        case (state_q)
            S_PRE: begin
                last_bit_s = (bit_q == PRE_LAST);
                succ_s     = S_HDR;
            end
            S_HDR: begin
                last_bit_s = (bit_q == HDR_LAST);
                succ_s     = S_TA;
            end
            S_TA: begin
                last_bit_s = (bit_q == TA_LAST);
                succ_s     = S_DATA;
            end
            S_DATA: begin
                last_bit_s = (bit_q == DATA_LAST);
                succ_s     = S_DONE;
            end
            default: begin
                last_bit_s = 1'b0;
                succ_s     = S_IDLE;
            end
        endcase
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_PRE;
                    div_d   = {DIV_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
                if (bit_end_s) begin
                    div_d = {DIV_W{1'b0}};
                    if (last_bit_s) begin
                        bit_d   = {BIT_W{1'b0}};
                        state_d = succ_s;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                div_d   = {DIV_W{1'b0}};
                bit_d   = {BIT_W{1'b0}};
            end
            default: begin
                state_d = S_IDLE;
                div_d   = {DIV_W{1'b0}};
                bit_d   = {BIT_W{1'b0}};
            end
        endcase
    end

    // Command latch, TA check capture and read shift register.
    always_comb begin
        rd_d     = rd_q;
        hdr_d    = hdr_q;
        wdata_d  = wdata_q;
        rx_d     = rx_q;
        ta_err_d = ta_err_q;
        if (accept_s) begin
            rd_d     = cmd_read;
            hdr_d    = {2'b01, (cmd_read ? 2'b10 : 2'b01), cmd_phy, cmd_reg};
            wdata_d  = cmd_wdata;
            rx_d     = 16'h0000;
            ta_err_d = 1'b0;
        end else begin
            if (bit_end_s && (state_q == S_TA) && (bit_q == TA_LAST)) begin
                ta_err_d = sync2_q;
            end else begin
                ta_err_d = ta_err_q;
            end
            if (bit_end_s && (state_q == S_DATA)) begin
                rx_d = {rx_q[14:0], sync2_q};
            end else begin
                rx_d = rx_q;
            end
        end
    end

    // Output next values, derived from the next position so that the
    // registered outputs line up with the cycle the counters describe.
    always_comb begin
        hdr_sh_s  = hdr_q << bit_d;
        wd_sh_s   = wdata_q << bit_d;
        busy_d    = (state_d != S_IDLE);
        ack_d     = (state_d == S_DONE);
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        case (state_d)
            S_PRE, S_HDR, S_TA, S_DATA: frame_s = 1'b1;
            default:                    frame_s = 1'b0;
        endcase
        mdc_d = frame_s && (div_d >= DIV_HALF);
        // Pin data only changes on the first clk of a low phase.
        if (div_d == {DIV_W{1'b0}}) begin
            case (state_d)
                S_PRE: begin
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = 1'b1;
                end
                S_HDR: begin
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = hdr_sh_s[13];
                end
                S_TA: begin
                    mdio_oe_d = !rd_q;
                    mdio_o_d  = rd_q ? 1'b1 : (bit_d == {BIT_W{1'b0}});
                end
                S_DATA: begin
                    mdio_oe_d = !rd_q;
                    mdio_o_d  = rd_q ? 1'b1 : wd_sh_s[15];
                end
                default: begin
                    mdio_oe_d = 1'b0;
                    mdio_o_d  = 1'b1;
                end
            endcase
        end else begin
            mdio_oe_d = mdio_oe_q;
            mdio_o_d  = mdio_o_q;
        end
        // rx_d already holds the final DATA bit on the edge into DONE.
        if ((state_d == S_DONE) && rd_q) begin
            rdata_d  = rx_d;
            rd_err_d = ta_err_q;
        end else begin
            rdata_d  = rdata_q;
            rd_err_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_mdio_master_c22.sv
module tb_mdio_master_c22;

    localparam int LAT = 2561;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_read;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        busy, ack, rd_err, mdc, mdio_o, mdio_oe, mdio_i;
    logic [15:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // PHY model controls (written only by the stimulus process)
    logic        phy_rd      = 1'b0;
    logic        phy_present = 1'b0;
    logic [15:0] phy_data    = 16'h0000;
    int          phy_falls   = 0;
    logic        phy_prev    = 1'b0;

    // monitor state
    int          mon_rises = 0;
    logic [63:0] mon_bits  = 64'd0;
    logic [63:0] mon_oes   = 64'd0;
    int          mon_run = 0, mon_acc_cyc = 0, mon_ack_total = 0;
    int          hi_min = 9999, hi_max = 0, lo_min = 9999, lo_max = 0;
    logic        mon_prev = 1'b0;
    int          stray_err = 0, idle_bad = 0;

    logic [15:0] model_rdata = 16'h0000;

    typedef struct {
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wdata;
        logic        present;
        logic [15:0] pdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    mdio_master_c22 #(.CLK_DIV(20), .PRE_BITS(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_read(cmd_read),
        .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .rd_err(rd_err),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PHY: bit k of the frame is on the line after k falling mdc edges.
    function automatic logic phy_bit(input int k, input logic prd, input logic pres,
                                     input logic [15:0] pd);
        if (!prd || !pres) return 1'b1;
        if (k == 47) return 1'b0;
        if (k >= 48 && k <= 63) return pd[63 - k];
        return 1'b1;
    endfunction

    assign mdio_i = mdio_oe ? mdio_o : phy_bit(phy_falls, phy_rd, phy_present, phy_data);

    always @(negedge clk) begin
        if (rst || (cmd_valid && !busy)) begin
            phy_falls <= 0;
            phy_prev  <= 1'b0;
        end else begin
            if (phy_prev && !mdc) phy_falls <= phy_falls + 1;
            phy_prev <= mdc;
        end
    end

    // Monitor: frame bits at mdc rise, phase lengths, ack count, idle pins.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev <= 1'b0;
            mon_run  <= 0;
        end else if (cmd_valid && !busy) begin
            mon_acc_cyc <= cyc;
            mon_rises   <= 0;
            mon_bits    <= 64'd0;
            mon_oes     <= 64'd0;
            mon_run     <= 0;
            mon_prev    <= 1'b0;
            hi_min <= 9999; hi_max <= 0; lo_min <= 9999; lo_max <= 0;
        end else begin
            if (mdc != mon_prev) begin
                mon_run <= 1;
                if (mon_prev) begin
                    if (mon_run < hi_min) hi_min <= mon_run;
                    if (mon_run > hi_max) hi_max <= mon_run;
                end else begin
                    if (mon_run < lo_min) lo_min <= mon_run;
                    if (mon_run > lo_max) lo_max <= mon_run;
                end
                if (mdc) begin
                    if (mon_rises < 64) begin
                        mon_bits[63 - mon_rises] <= mdio_o;
                        mon_oes[63 - mon_rises]  <= mdio_oe;
                    end
                    mon_rises <= mon_rises + 1;
                end
            end else begin
                mon_run <= mon_run + 1;
            end
            mon_prev <= mdc;
        end
        if (!rst) begin
            if (ack) mon_ack_total <= mon_ack_total + 1;
            if (rd_err && !ack) stray_err <= stray_err + 1;
            if ((!busy || ack) && (mdc || mdio_oe)) idle_bad <= idle_bad + 1;
            if (!busy && !mdio_o) idle_bad <= idle_bad + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic rd, input logic [4:0] phy,
                                              input logic [4:0] rg, input logic [15:0] wd);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), phy, rg, 2'b10, wd};
    endfunction

    task automatic wait_ack(input string tag, output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_ack_seen"}, {63'd0, got}, 64'd1);
    endtask

    // Checks made on the ack cycle: latency, results, and the captured frame.
    task automatic check_ack(input string tag, input logic rd, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wd,
                             input logic [15:0] exp_rdata, input logic exp_err);
        logic [63:0] mask;
        mask = rd ? 64'hFFFF_FFFF_FFFC_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
        chk({tag, "_latency"}, 64'(cyc - mon_acc_cyc), 64'(LAT));
        chk({tag, "_rdata"}, {48'd0, rdata}, {48'd0, exp_rdata});
        chk({tag, "_rd_err"}, {63'd0, rd_err}, {63'd0, exp_err});
        chk({tag, "_ack_pins"}, {61'd0, busy, mdc, mdio_oe}, 64'd4);
        chk({tag, "_rises"}, 64'(mon_rises), 64'd64);
        chk({tag, "_bits"}, mon_bits & mask, exp_frame(rd, phy, rg, wd) & mask);
        chk({tag, "_oe"}, mon_oes, mask);
        chk({tag, "_mdc_phase"}, {16'(hi_min), 16'(hi_max), 16'(lo_min), 16'(lo_max)},
            {16'd20, 16'd20, 16'd20, 16'd20});
    endtask

    task automatic run_cmd(input string tag, input logic rd, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input logic present,
                           input logic [15:0] pdata, input logic [15:0] exp_rdata,
                           input logic exp_err);
        int a0;
        bit got;
        a0 = mon_ack_total;
        phy_rd = rd; phy_present = present; phy_data = pdata;
        @(posedge clk); #1;
        cmd_read = rd; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
        @(negedge clk); #1;
        chk({tag, "_ready"}, {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_wdata = ~wd;
        @(negedge clk); #1;
        chk({tag, "_busy_c1"}, {62'd0, busy, ack}, 64'd2);
        wait_ack(tag, got);
        if (got) check_ack(tag, rd, phy, rg, wd, exp_rdata, exp_err);
        @(negedge clk); #1;
        chk({tag, "_after_ack"}, {61'd0, busy, ack, rd_err}, 64'd0);
        chk({tag, "_rdata_held"}, {48'd0, rdata}, {48'd0, exp_rdata});
        chk({tag, "_ack_count"}, 64'(mon_ack_total - a0), 64'd1);
    endtask

    initial begin
        bit got;
        int a0, ack1;
        logic rd, pres;
        logic [4:0] phy, rg;
        logic [15:0] wd, pd, er;

        vecs[0] = '{1'b0, 5'd1,  5'd0,  16'h4000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 5'd1,  5'd2,  16'h0000, 1'b1, 16'h2215, 16'h2215, 1'b0};
        vecs[2] = '{1'b1, 5'd5,  5'd3,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b0, 5'd3,  5'd4,  16'hA5C3, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b1, 5'd31, 5'd31, 16'h0000, 1'b1, 16'h0001, 16'h0001, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0;
        cmd_phy = 5'd0; cmd_reg = 5'd0; cmd_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_pins", {58'd0, busy, ack, rd_err, mdc, mdio_o, mdio_oe}, 64'd2);
        chk("reset_rdata", {48'd0, rdata}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("idle_pins", {58'd0, busy, ack, rd_err, mdc, mdio_o, mdio_oe}, 64'd2);

        // table-driven commands
        for (int i = 0; i < 5; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].rd, vecs[i].phy, vecs[i].rg,
                    vecs[i].wdata, vecs[i].present, vecs[i].pdata,
                    vecs[i].exp_rdata, vecs[i].exp_err);
            model_rdata = vecs[i].exp_rdata;
        end

        // back-to-back writes with cmd_valid held high
        a0 = mon_ack_total;
        phy_rd = 1'b0;
        @(posedge clk); #1;
        cmd_read = 1'b0; cmd_phy = 5'd2; cmd_reg = 5'd4; cmd_wdata = 16'h1234; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_phy = 5'd7; cmd_reg = 5'd9; cmd_wdata = 16'hBEEF;
        wait_ack("b2b_first", got);
        ack1 = cyc;
        if (got) check_ack("b2b_first", 1'b0, 5'd2, 5'd4, 16'h1234, model_rdata, 1'b0);
        @(negedge clk); #1;
        chk("b2b_accept_cycle", 64'(mon_acc_cyc), 64'(ack1 + 1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_ack("b2b_second", got);
        if (got) check_ack("b2b_second", 1'b0, 5'd7, 5'd9, 16'hBEEF, model_rdata, 1'b0);
        repeat (50) @(negedge clk);
        #1;
        chk("b2b_ack_count", 64'(mon_ack_total - a0), 64'd2);

        // reset in the middle of DATA bit 3 of a write
        a0 = mon_ack_total;
        @(posedge clk); #1;
        cmd_read = 1'b0; cmd_phy = 5'd1; cmd_reg = 5'd0; cmd_wdata = 16'h5A5A; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (mon_rises == 52) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_reach_data3", {63'd0, got}, 64'd1);
        chk("rst_pre_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_pins", {58'd0, busy, ack, rd_err, mdc, mdio_o, mdio_oe}, 64'd2);
        chk("rst_async_rdata", {48'd0, rdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        chk("rst_no_ack", 64'(mon_ack_total - a0), 64'd0);
        chk("rst_idle_pins", {58'd0, busy, ack, rd_err, mdc, mdio_o, mdio_oe}, 64'd2);
        model_rdata = 16'h0000;
        run_cmd("post_rst_read", 1'b1, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h2215, 16'h2215, 1'b0);
        model_rdata = 16'h2215;

        // randomized commands against the reference model
        for (int i = 0; i < 6; i++) begin
            rd   = 1'($urandom_range(0, 1));
            phy  = 5'($urandom);
            rg   = 5'($urandom);
            wd   = 16'($urandom);
            pd   = 16'($urandom);
            pres = ($urandom_range(0, 3) != 0);
            er   = rd ? (pres ? pd : 16'hFFFF) : model_rdata;
            run_cmd($sformatf("rnd%0d", i), rd, phy, rg, wd, pres, pd, er, rd && !pres);
            model_rdata = er;
        end

        chk("stray_rd_err", 64'(stray_err), 64'd0);
        chk("idle_pin_violations", 64'(idle_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
